// File: rtl/dstack_pkg.sv
// Shared definitions for the J1 data-stack controller: operation codes used
// by both core decode and the controller, plus the controller FSM encoding.
package dstack_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_REPL  = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_DUP   = 3'd5;
  localparam logic [2:0] OP_DROPN = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DROP = 1'b1
  } state_t;

endpackage

// File: rtl/dstack_ctrl.sv
// Data-stack controller: keeps top-of-stack in a register, the rest of the
// stack in an external async-read RAM, and runs multi-cycle DROPN in a
// small two-state FSM. Overflow/underflow are sticky until err_clr.
module dstack_ctrl
  import dstack_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_code,
  input  logic [WIDTH-1:0]      op_data,
  input  logic [7:0]            op_n,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      T,
  output logic [WIDTH-1:0]      N,
  output logic [DEPTH_LOG2:0]   depth,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  unf,
  output logic                  st_wen,
  output logic [DEPTH_LOG2-1:0] st_wa,
  output logic [WIDTH-1:0]      st_wd,
  output logic [DEPTH_LOG2-1:0] st_ra,
  input  logic [WIDTH-1:0]      st_rd
);

  // Item count (including T) at which the stack is full.
  localparam logic [DEPTH_LOG2:0] C_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t                r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_t, w_t_nxt;
  logic                  r_t_valid, w_t_valid_nxt;
  logic [DEPTH_LOG2-1:0] r_dsp, w_dsp_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic                  r_ovf, r_unf;
  logic                  w_ovf_set, w_unf_set;

  logic [DEPTH_LOG2:0]   w_depth;
  logic [DEPTH_LOG2-1:0] w_dsp_m1;
  logic                  w_dsp_zero;
  logic                  w_full, w_empty, w_fire;

  // t_valid==0 implies dsp==0, so depth never wraps past C_FULL.
  assign w_depth    = {1'b0, r_dsp} + {{DEPTH_LOG2{1'b0}}, r_t_valid};
  assign w_dsp_m1   = r_dsp - DEPTH_LOG2'(1);
  assign w_dsp_zero = (r_dsp == '0);
  assign w_full     = (w_depth == C_FULL);
  assign w_empty    = (w_depth == '0);
  assign w_fire     = op_valid && (r_state == ST_IDLE);

  assign op_ready = (r_state == ST_IDLE);
  assign T        = r_t;
  assign N        = w_dsp_zero ? '0 : st_rd;
  assign depth    = w_depth;
  assign full     = w_full;
  assign empty    = w_empty;
  assign ovf      = r_ovf;
  assign unf      = r_unf;
  assign st_ra    = w_dsp_zero ? '0 : w_dsp_m1;

  // Next-state, datapath updates and storage write strobe for this cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_state_nxt   = r_state;
    w_t_nxt       = r_t;
    w_t_valid_nxt = r_t_valid;
    w_dsp_nxt     = r_dsp;
    w_cnt_nxt     = r_cnt;
    w_ovf_set     = 1'b0;
    w_unf_set     = 1'b0;
    st_wen        = 1'b0;
    st_wa         = r_dsp;
    st_wd         = r_t;

    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          case (op_code)
            OP_PUSH: begin
              if (w_full) begin
                w_ovf_set = 1'b1;
              end else begin
                if (r_t_valid) begin
                  st_wen    = 1'b1;
                  w_dsp_nxt = r_dsp + DEPTH_LOG2'(1);
                end
                w_t_nxt       = op_data;
                w_t_valid_nxt = 1'b1;
              end
            end
            OP_DUP: begin
              if (w_empty) begin
                w_unf_set = 1'b1;
              end else if (w_full) begin
                w_ovf_set = 1'b1;
              end else begin
                st_wen    = 1'b1;
                w_dsp_nxt = r_dsp + DEPTH_LOG2'(1);
              end
            end
            OP_POP: begin
              if (w_empty) begin
                w_unf_set = 1'b1;
              end else if (w_dsp_zero) begin
                w_t_nxt       = '0;
                w_t_valid_nxt = 1'b0;
              end else begin
                w_t_nxt   = st_rd;
                w_dsp_nxt = w_dsp_m1;
              end
            end
            OP_REPL: begin
              if (w_empty) w_unf_set = 1'b1;
              else         w_t_nxt   = op_data;
            end
            OP_SWAP: begin
              // Storage reads before it writes, so st_rd is still the old N.
              if (w_depth < (DEPTH_LOG2+1)'(2)) begin
                w_unf_set = 1'b1;
              end else begin
                w_t_nxt = st_rd;
                st_wen  = 1'b1;
                st_wa   = w_dsp_m1;
              end
            end
            OP_DROPN: begin
              if (op_n != 8'd0) begin
                w_cnt_nxt   = op_n;
                w_state_nxt = ST_DROP;
              end
            end
            OP_CLEAR: begin
              w_t_nxt       = '0;
              w_t_valid_nxt = 1'b0;
              w_dsp_nxt     = '0;
            end
            default: ;
          endcase
        end
      end
      ST_DROP: begin
        if (w_empty) begin
          w_unf_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_dsp_zero) begin
            w_t_nxt       = '0;
            w_t_valid_nxt = 1'b0;
          end else begin
            w_t_nxt   = st_rd;
            w_dsp_nxt = w_dsp_m1;
          end
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and datapath, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments.
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_t       <= '0;
      r_t_valid <= 1'b0;
      r_dsp     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_t       <= w_t_nxt;
      r_t_valid <= w_t_valid_nxt;
      r_dsp     <= w_dsp_nxt;
      r_cnt     <= w_cnt_nxt;
      // A new error in the same cycle as err_clr keeps the flag set.
      r_ovf     <= w_ovf_set | (r_ovf & ~err_clr);
      r_unf     <= w_unf_set | (r_unf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_dstack_ctrl.sv
// Self-checking bench for dstack_ctrl: directed vector table, hand-written
// corner sequences, then random ops against a queue-based stack model.
module tb_dstack_ctrl;
  import dstack_pkg::*;

  localparam int WIDTH      = 16;
  localparam int DEPTH_LOG2 = 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  op_valid;
  logic                  op_ready;
  logic [2:0]            op_code;
  logic [WIDTH-1:0]      op_data;
  logic [7:0]            op_n;
  logic                  err_clr;
  logic [WIDTH-1:0]      T, N;
  logic [DEPTH_LOG2:0]   depth;
  logic                  full, empty, ovf, unf;
  logic                  st_wen;
  logic [DEPTH_LOG2-1:0] st_wa, st_ra;
  logic [WIDTH-1:0]      st_wd, st_rd;

  logic [WIDTH-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dstack_ctrl #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_data(op_data), .op_n(op_n), .err_clr(err_clr),
    .T(T), .N(N), .depth(depth), .full(full), .empty(empty),
    .ovf(ovf), .unf(unf), .st_wen(st_wen), .st_wa(st_wa), .st_wd(st_wd),
    .st_ra(st_ra), .st_rd(st_rd)
  );

  // Behavioural stack RAM: async read, synchronous write.
  assign st_rd = mem[st_ra];
  always @(posedge clk) if (st_wen) mem[st_wa] <= st_wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {op_ready, full, empty, ovf, unf, depth, N, T}
  function automatic logic [63:0] pack_dut();
    return {18'd0, op_ready, full, empty, ovf, unf, depth, N, T};
  endfunction

  function automatic logic [63:0] pack_exp(input logic rdy, input logic fl, input logic em,
                                           input logic ov, input logic un, input int dp,
                                           input logic [15:0] nn, input logic [15:0] tt);
    logic [8:0] d9;
    d9 = 9'(dp);
    return {18'd0, rdy, fl, em, ov, un, d9, nn, tt};
  endfunction

  // Drive one cycle of inputs (called at a negedge), return at the next negedge.
  task automatic step(input logic v, input logic [2:0] op, input logic [15:0] d,
                      input logic [7:0] n, input logic clr);
    op_valid = v; op_code = op; op_data = d; op_n = n; err_clr = clr;
    @(negedge clk);
    op_valid = 1'b0; err_clr = 1'b0;
  endtask

  // Count cycles with op_ready low, bounded.
  task automatic busy_cycles(output int cnt);
    cnt = 0;
    while (!op_ready && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Reference model: queue back is top of stack.
  logic [15:0] q[$];
  logic        m_ovf, m_unf;
  int          m_pend;

  task automatic model_step(input logic v, input logic [2:0] op, input logic [15:0] d,
                            input logic [7:0] n, input logic clr);
    logic so, su;
    logic [15:0] tmp;
    so = 1'b0; su = 1'b0;
    if (m_pend != 0) begin
      if (q.size() == 0) begin su = 1'b1; m_pend = 0; end
      else begin void'(q.pop_back()); m_pend--; end
    end else if (v) begin
      case (op)
        OP_PUSH:  if (q.size() == DEPTH) so = 1'b1; else q.push_back(d);
        OP_POP:   if (q.size() == 0) su = 1'b1; else void'(q.pop_back());
        OP_REPL:  if (q.size() == 0) su = 1'b1; else q[q.size()-1] = d;
        OP_SWAP:  if (q.size() < 2) su = 1'b1;
                  else begin
                    tmp = q[q.size()-1];
                    q[q.size()-1] = q[q.size()-2];
                    q[q.size()-2] = tmp;
                  end
        OP_DUP:   if (q.size() == 0) su = 1'b1;
                  else if (q.size() == DEPTH) so = 1'b1;
                  else q.push_back(q[q.size()-1]);
        OP_DROPN: m_pend = int'(n);
        OP_CLEAR: q.delete();
        default: ;
      endcase
    end
    m_ovf = so | (m_ovf & ~clr);
    m_unf = su | (m_unf & ~clr);
  endtask

  function automatic logic [63:0] model_exp();
    logic [15:0] tt, nn;
    int sz;
    sz = q.size();
    tt = (sz >= 1) ? q[sz-1] : 16'h0;
    nn = (sz >= 2) ? q[sz-2] : 16'h0;
    return pack_exp(m_pend == 0, sz == DEPTH, sz == 0, m_ovf, m_unf, sz, nn, tt);
  endfunction

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] data;
    logic [15:0] exp_t;
    logic [15:0] exp_n;
    logic [8:0]  exp_depth;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc;
    vecs[0] = '{OP_PUSH,  16'h1111, 16'h1111, 16'h0000, 9'd1};
    vecs[1] = '{OP_PUSH,  16'h2222, 16'h2222, 16'h1111, 9'd2};
    vecs[2] = '{OP_PUSH,  16'h3333, 16'h3333, 16'h2222, 9'd3};
    vecs[3] = '{OP_SWAP,  16'h0000, 16'h2222, 16'h3333, 9'd3};
    vecs[4] = '{OP_POP,   16'h0000, 16'h3333, 16'h1111, 9'd2};
    vecs[5] = '{OP_REPL,  16'h4444, 16'h4444, 16'h1111, 9'd2};
    vecs[6] = '{OP_DUP,   16'h0000, 16'h4444, 16'h4444, 9'd3};
    vecs[7] = '{OP_POP,   16'h0000, 16'h4444, 16'h1111, 9'd2};
    vecs[8] = '{OP_CLEAR, 16'h0000, 16'h0000, 16'h0000, 9'd0};

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst_n = 1'b0; op_valid = 1'b0; op_code = OP_NOP; op_data = '0; op_n = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check("reset_outputs", pack_dut(), pack_exp(1, 0, 1, 0, 0, 0, 16'h0, 16'h0));
    check("reset_storage", {62'd0, st_wen, |st_ra}, 64'd0);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, vecs[i].op, vecs[i].data, 8'd0, 1'b0);
      check($sformatf("vec%0d", i), {31'd0, depth, N, T},
            {31'd0, vecs[i].exp_depth, vecs[i].exp_n, vecs[i].exp_t});
      if (i == 2) check("push_writes", {32'd0, mem[0], mem[1]}, {32'd0, 16'h1111, 16'h2222});
    end

    // Fill to capacity, then overflow and clear the flag.
    for (int i = 0; i < DEPTH; i++) step(1'b1, OP_PUSH, 16'(i), 8'd0, 1'b0);
    check("full", pack_dut(), pack_exp(1, 1, 0, 0, 0, DEPTH, 16'd254, 16'd255));
    step(1'b1, OP_PUSH, 16'hBEEF, 8'd0, 1'b0);
    check("overflow", pack_dut(), pack_exp(1, 1, 0, 1, 0, DEPTH, 16'd254, 16'd255));
    step(1'b1, OP_DUP, 16'h0, 8'd0, 1'b0);
    check("dup_full", pack_dut(), pack_exp(1, 1, 0, 1, 0, DEPTH, 16'd254, 16'd255));
    step(1'b0, OP_NOP, 16'h0, 8'd0, 1'b1);
    check("ovf_clear", pack_dut(), pack_exp(1, 1, 0, 0, 0, DEPTH, 16'd254, 16'd255));

    // Underflow on empty.
    step(1'b1, OP_CLEAR, 16'h0, 8'd0, 1'b0);
    step(1'b1, OP_POP, 16'h0, 8'd0, 1'b0);
    check("pop_empty", pack_dut(), pack_exp(1, 0, 1, 0, 1, 0, 16'h0, 16'h0));
    step(1'b1, OP_REPL, 16'h0005, 8'd0, 1'b0);
    check("repl_empty", pack_dut(), pack_exp(1, 0, 1, 0, 1, 0, 16'h0, 16'h0));
    step(1'b1, OP_POP, 16'h0, 8'd0, 1'b1);
    check("err_wins_clr", pack_dut(), pack_exp(1, 0, 1, 0, 1, 0, 16'h0, 16'h0));
    step(1'b0, OP_NOP, 16'h0, 8'd0, 1'b1);
    check("unf_clear", pack_dut(), pack_exp(1, 0, 1, 0, 0, 0, 16'h0, 16'h0));

    // DROPN within and beyond depth.
    for (int i = 1; i <= 5; i++) step(1'b1, OP_PUSH, 16'(i), 8'd0, 1'b0);
    step(1'b1, OP_DROPN, 16'h0, 8'd3, 1'b0);
    busy_cycles(cyc);
    check("dropn3_busy", 64'(cyc), 64'd3);
    check("dropn3_state", pack_dut(), pack_exp(1, 0, 0, 0, 0, 2, 16'd1, 16'd2));
    step(1'b1, OP_DROPN, 16'h0, 8'd4, 1'b0);
    busy_cycles(cyc);
    check("dropn4_busy", 64'(cyc), 64'd3);
    check("dropn4_state", pack_dut(), pack_exp(1, 0, 1, 0, 1, 0, 16'h0, 16'h0));
    step(1'b1, OP_DROPN, 16'h0, 8'd0, 1'b0);
    check("dropn0_noop", pack_dut(), pack_exp(1, 0, 1, 0, 1, 0, 16'h0, 16'h0));

    // Reset in the middle of DROPN (unf is still set from above).
    for (int i = 1; i <= 8; i++) step(1'b1, OP_PUSH, 16'(i), 8'd0, 1'b0);
    step(1'b1, OP_DROPN, 16'h0, 8'd10, 1'b0);
    check("dropn10_busy1", {63'd0, op_ready}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_drop", pack_dut(), pack_exp(1, 0, 1, 0, 0, 0, 16'h0, 16'h0));
    rst_n = 1'b1;

    // Random ops against the queue model.
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      logic       v, clr;
      logic [2:0] op;
      logic [15:0] d;
      logic [7:0] n;
      check($sformatf("rand_cyc%0d", c), pack_dut(), model_exp());
      v   = ($urandom_range(0, 9) < 8);
      op  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = OP_PUSH;
      d   = 16'($urandom);
      n   = 8'($urandom_range(0, 5));
      clr = ($urandom_range(0, 19) == 0);
      model_step(v, op, d, n, clr);
      step(v, op, d, n, clr);
    end
    check("rand_final", pack_dut(), model_exp());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
